// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - states, default timing and address field ranges for the expansion DRAM controller
package dram_pkg;

  // Bus/refresh sequencer states
  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    ACK,
    PRECHARGE,
    REF_CAS,
    REF_RAS
  } dram_state_t;

  // Default timing, in CLK cycles (8 MHz CPU clock)
  localparam int REFRESH_DIV_DEF = 124;
  localparam int T_RCD_DEF       = 1;
  localparam int T_RAS_DEF       = 2;
  localparam int T_RP_DEF        = 2;

  // Width of the per-state cycle counter; covers timing values up to 15
  localparam int CNT_W = 4;

  // Bus address is byte address [22:1]; port bit 0 is byte address bit 1
  localparam int ADDR_W  = 22;
  localparam int MA_W    = 11;
  localparam int ROW_MSB = 21;
  localparam int ROW_LSB = 11;
  localparam int COL_MSB = 10;
  localparam int COL_LSB = 0;

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - refresh interval counter and pending-refresh tracking (DRAM_REFRESH_DEBT_EN adds a 2-bit debt counter)
module dram_refresh_timer #(
  parameter int REFRESH_DIV = 124
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_consume,
  output logic o_pending
);

  localparam int DIV_W = $clog2(REFRESH_DIV + 1);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_count;
  logic             w_tick;

  // A tick is visible in the same cycle the counter hits zero, so the
  // sequencer can weigh it against a bus cycle sampled on that edge.
  assign w_tick = (r_count == '0);

  // Free-running down-counter, independent of bus activity
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= RELOAD;
    end else if (w_tick) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - DIV_W'(1);
    end
  end

`ifdef DRAM_REFRESH_DEBT_EN
  logic [1:0] r_debt;

  // Saturating count of owed refreshes; tick plus consume cancels out
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_debt <= 2'd0;
    end else if (w_tick && !i_consume && (r_debt != 2'd3)) begin
      r_debt <= r_debt + 2'd1;
    end else if (!w_tick && i_consume && (r_debt != 2'd0)) begin
      r_debt <= r_debt - 2'd1;
    end
  end

  assign o_pending = w_tick || (r_debt != 2'd0);
`else
  logic r_pend;

  // Single pending flag; a tick while already pending is dropped
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
    end else if (w_tick && !i_consume) begin
      r_pend <= 1'b1;
    end else if (!w_tick && i_consume) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pending = w_tick || r_pend;
`endif

endmodule

// File: rtl/dram_controller.sv
// rtl/dram_controller.sv - 68000 bus to RAS/CAS sequencer with CBR refresh for one 4M x16 bank (DRAM_REFRESH_DEBT_EN selects refresh debt)
module dram_controller
  import dram_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int T_RCD       = T_RCD_DEF,
  parameter int T_RAS       = T_RAS_DEF,
  parameter int T_RP        = T_RP_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              AS,
  input  logic              UDS,
  input  logic              LDS,
  input  logic              RW,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [MA_W-1:0]   MA,
  output logic              RAS,
  output logic              CASU,
  output logic              CASL,
  output logic              WE,
  output logic              DTACK
);

  localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_LAST = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);

  dram_state_t      r_state;
  dram_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pending;
  logic             w_consume;
  logic             w_start;
  logic [MA_W-1:0]  w_row;
  logic [MA_W-1:0]  w_col;

  logic [MA_W-1:0]  r_ma;
  logic             r_ras;
  logic             r_casu;
  logic             r_casl;
  logic             r_we;
  logic             r_dtack;

  assign w_row   = ADDR[ROW_MSB:ROW_LSB];
  assign w_col   = ADDR[COL_MSB:COL_LSB];
  assign w_start = !CS && !AS;

  // The pending refresh is taken on the edge that enters REF_CAS
  assign w_consume = (w_next == REF_CAS);

  dram_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_timer (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_consume(w_consume),
    .o_pending(w_pending)
  );

  // Next-state selection; the end of precharge makes the same choice as IDLE
  // so a queued access or refresh does not lose a cycle in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pending)    w_next = REF_CAS;
        else if (w_start) w_next = ROW;
      end
      ROW: begin
        if (AS)                     w_next = PRECHARGE;
        else if (r_cnt == RCD_LAST) w_next = COL;
      end
      COL: begin
        if (AS)                w_next = PRECHARGE;
        else if (!UDS || !LDS) w_next = ACK;
      end
      ACK: begin
        if (AS) w_next = PRECHARGE;
      end
      PRECHARGE: begin
        if (r_cnt == RP_LAST) begin
          if (w_pending)    w_next = REF_CAS;
          else if (w_start) w_next = ROW;
          else              w_next = IDLE;
        end
      end
      REF_CAS: w_next = REF_RAS;
      REF_RAS: begin
        if (r_cnt == RAS_LAST) w_next = PRECHARGE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register and per-state cycle counter (restarts on every state change)
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered DRAM/bus outputs; CAS latches strobes only while already in
  // COL, and DTACK drops one cycle after ACK is entered.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ma    <= '0;
      r_ras   <= 1'b1;
      r_casu  <= 1'b1;
      r_casl  <= 1'b1;
      r_we    <= 1'b1;
      r_dtack <= 1'b1;
    end else begin
      case (w_next)
        ROW: begin
          r_ras   <= 1'b0;
          r_ma    <= w_row;
          r_we    <= RW;
          r_casu  <= 1'b1;
          r_casl  <= 1'b1;
          r_dtack <= 1'b1;
        end
        COL, ACK: begin
          r_ras <= 1'b0;
          r_ma  <= w_col;
          if (r_state == COL) begin
            r_casu <= r_casu & UDS;
            r_casl <= r_casl & LDS;
          end
          r_dtack <= !(r_state == ACK);
        end
        REF_CAS: begin
          r_ras   <= 1'b1;
          r_casu  <= 1'b0;
          r_casl  <= 1'b0;
          r_we    <= 1'b1;
          r_dtack <= 1'b1;
        end
        REF_RAS: begin
          r_ras   <= 1'b0;
          r_we    <= 1'b1;
          r_dtack <= 1'b1;
        end
        default: begin
          r_ras   <= 1'b1;
          r_casu  <= 1'b1;
          r_casl  <= 1'b1;
          r_we    <= 1'b1;
          r_dtack <= 1'b1;
        end
      endcase
    end
  end

  assign MA    = r_ma;
  assign RAS   = r_ras;
  assign CASU  = r_casu;
  assign CASL  = r_casl;
  assign WE    = r_we;
  assign DTACK = r_dtack;

endmodule
